// File: rtl/sm83_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sm83_irq_ctrl
// Purpose  : SM83 interrupt controller. Holds IF/IE and IME with delayed-EI
//            behaviour, arbitrates pending sources by fixed priority (bit 0
//            highest) at instruction boundaries, and runs a request/ack
//            dispatch handshake with the control FSM. The vector is tracked
//            live while requesting; it reads 0 if every source disappears
//            before the ack (cancelled dispatch).
// Ports    : clk, rst_n (async, active low)
//            irq_src            raw source levels, rising edge latches IF
//            if_wr_en/if_wr_data, ie_wr_en/ie_wr_data  software writes
//            if_q, ie_q, ime_q  register readback
//            ctl_di/ctl_ei/ctl_reti, instr_boundary   core control events
//            wake               |(IF & IE), ignores IME (HALT exit)
//            irq_req/irq_ack/irq_vec  dispatch handshake
// Revision : 1.0  initial release
// ============================================================================
module sm83_irq_ctrl #(
  parameter int          N_IRQ      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             if_wr_en,
  input  logic [N_IRQ-1:0] if_wr_data,
  input  logic             ie_wr_en,
  input  logic [N_IRQ-1:0] ie_wr_data,
  output logic [N_IRQ-1:0] if_q,
  output logic [N_IRQ-1:0] ie_q,
  input  logic             ctl_di,
  input  logic             ctl_ei,
  input  logic             ctl_reti,
  input  logic             instr_boundary,
  output logic             ime_q,
  output logic             wake,
  output logic             irq_req,
  input  logic             irq_ack,
  output logic [15:0]      irq_vec
);

  localparam int         c_sel_w   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_req  = 1'b1;

  logic [N_IRQ-1:0] r_if;
  logic [N_IRQ-1:0] r_ie;
  logic [N_IRQ-1:0] r_src_prev;
  logic             r_ime;
  logic             r_ei_pending;
  logic [0:0]       r_state;

  logic [N_IRQ-1:0] w_pend_vec;
  logic             w_pending_any;
  logic [c_sel_w-1:0] w_sel;
  logic [N_IRQ-1:0] w_sel_onehot;
  logic [N_IRQ-1:0] w_rise;
  logic             w_commit;
  logic [N_IRQ-1:0] w_if_nxt;
  logic             w_ime_nxt;
  logic             w_eip_nxt;
  logic [15:0]      w_vec;

  // Fixed-priority pick: scanning from the top down leaves the lowest set
  // index in w_sel. The one-hot mask is all zero when nothing is pending,
  // so a cancelled dispatch clears no IF bit.
  always_comb begin
    w_pend_vec    = r_if & r_ie;
    w_pending_any = |w_pend_vec;
    w_sel         = '0;
    w_sel_onehot  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pend_vec[i]) begin
        w_sel           = c_sel_w'(i);
        w_sel_onehot    = '0;
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  assign w_rise   = irq_src & ~r_src_prev;
  assign w_commit = (r_state == c_st_req) && irq_ack;

  // Applied lowest-priority first so later steps override per bit:
  // software write, then ack clear, then edge set.
  always_comb begin
    w_if_nxt = r_if;
    if (if_wr_en) begin
      w_if_nxt = if_wr_data;
    end
    if (w_commit) begin
      w_if_nxt = w_if_nxt & ~w_sel_onehot;
    end
    w_if_nxt = w_if_nxt | w_rise;
  end

  // IME update, lowest priority first. EI only arms ei_pending; IME itself
  // rises at the following boundary, so the instruction after EI runs with
  // interrupts still disabled.
  always_comb begin
    w_ime_nxt = r_ime;
    w_eip_nxt = r_ei_pending;
    if (instr_boundary && r_ei_pending) begin
      w_ime_nxt = 1'b1;
      w_eip_nxt = 1'b0;
    end
    if (ctl_ei) begin
      w_eip_nxt = 1'b1;
    end
    if (ctl_reti) begin
      w_ime_nxt = 1'b1;
      w_eip_nxt = 1'b0;
    end
    if (ctl_di || w_commit) begin
      w_ime_nxt = 1'b0;
      w_eip_nxt = 1'b0;
    end
  end

  // 16-bit operands keep the result modulo 2^16.
  assign w_vec = VEC_BASE + ({{(16 - c_sel_w){1'b0}}, w_sel} * VEC_STRIDE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if         <= '0;
      r_ie         <= '0;
      r_src_prev   <= '0;
      r_ime        <= 1'b0;
      r_ei_pending <= 1'b0;
      r_state      <= c_st_idle;
    end else begin
      r_if         <= w_if_nxt;
      r_src_prev   <= irq_src;
      r_ime        <= w_ime_nxt;
      r_ei_pending <= w_eip_nxt;
      if (ie_wr_en) begin
        r_ie <= ie_wr_data;
      end
      case (r_state)
        c_st_idle: begin
          // r_ime is the pre-update value, so an EI retiring on this same
          // boundary cannot trigger a dispatch yet.
          if (instr_boundary && r_ime && w_pending_any) begin
            r_state <= c_st_req;
          end
        end
        c_st_req: begin
          // DI does not withdraw an outstanding request; only ack ends it.
          if (irq_ack) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign if_q    = r_if;
  assign ie_q    = r_ie;
  assign ime_q   = r_ime;
  assign wake    = w_pending_any;
  assign irq_req = (r_state == c_st_req);
  assign irq_vec = ((r_state == c_st_req) && w_pending_any) ? w_vec : 16'h0000;

endmodule
`default_nettype wire
